// File: rtl/wb_unit.sv
// Write-back / retire stage: picks the register-file write for each retiring instruction,
// owns the HI/LO registers, waits on load data with a 16-cycle timeout, and counts retirements.
module wb_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Ins,
  input  logic [31:0] Alu_result,
  input  logic [31:0] Link_pc,
  input  logic [31:0] Md_hi,
  input  logic [31:0] Md_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err,
  output logic [31:0] retired
);

  // MIPS-I opcode / funct encodings
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_JAL  = 6'h03, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b,
                         OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_XORI = 6'h0e,
                         OP_LW    = 6'h23;
  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04,
                         F_SRLV = 6'h06, F_SRAV = 6'h07, F_JALR = 6'h09, F_MFHI = 6'h10,
                         F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13, F_MULT = 6'h18,
                         F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b, F_ADD  = 6'h20,
                         F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU = 6'h23, F_AND  = 6'h24,
                         F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2a,
                         F_SLTU = 6'h2b;

  typedef enum logic {IDLE, LOADWAIT} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [4:0]  ld_rt;

  logic [5:0]  op, funct;
  logic [4:0]  rt, rd;
  logic        dec_write, dec_load, dec_hi_we, dec_lo_we;
  logic [4:0]  dec_addr;
  logic [31:0] dec_data, dec_hi_val, dec_lo_val;
  logic        unused_fields;

  assign op            = Ins[31:26];
  assign rt            = Ins[20:16];
  assign rd            = Ins[15:11];
  assign funct         = Ins[5:0];
  assign unused_fields = ^{Ins[25:21], Ins[10:6]};

  assign in_ready = (state == IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    dec_write  = 1'b0;
    dec_load   = 1'b0;
    dec_hi_we  = 1'b0;
    dec_lo_we  = 1'b0;
    dec_addr   = rd;
    dec_data   = Alu_result;
    dec_hi_val = Md_hi;
    dec_lo_val = Md_lo;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU,
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: dec_write = 1'b1;
          F_JALR: begin dec_write = 1'b1; dec_data = Link_pc; end
          F_MFHI: begin dec_write = 1'b1; dec_data = hi; end
          F_MFLO: begin dec_write = 1'b1; dec_data = lo; end
          F_MTHI: begin dec_hi_we = 1'b1; dec_hi_val = Alu_result; end
          F_MTLO: begin dec_lo_we = 1'b1; dec_lo_val = Alu_result; end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin dec_hi_we = 1'b1; dec_lo_we = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        dec_write = 1'b1;
        dec_addr  = rt;
      end
      OP_JAL: begin
        dec_write = 1'b1;
        dec_addr  = 5'd31;
        dec_data  = Link_pc;
      end
      OP_LW:   dec_load = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      ld_rt    <= 5'd0;
      we       <= 1'b0;
      waddr    <= 5'd0;
      wdata    <= 32'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      err      <= 1'b0;
      retired  <= 32'd0;
    end else begin
      // NOTE: non-blocking default; a later assignment in this block overrides it for a one-cycle pulse.
      we <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (dec_load) begin
              ld_rt    <= rt;
              wait_cnt <= 4'd0;
              state    <= LOADWAIT;
            end else begin
              retired <= retired + 32'd1;
              if (dec_hi_we) hi <= dec_hi_val;
              if (dec_lo_we) lo <= dec_lo_val;
              // r0 writes are dropped and leave waddr/wdata untouched
              if (dec_write && dec_addr != 5'd0) begin
                we    <= 1'b1;
                waddr <= dec_addr;
                wdata <= dec_data;
              end
            end
          end
        end
        LOADWAIT: begin
          if (mem_rvalid) begin
            state   <= IDLE;
            retired <= retired + 32'd1;
            if (ld_rt != 5'd0) begin
              we    <= 1'b1;
              waddr <= ld_rt;
              wdata <= mem_rdata;
            end
          end else if (wait_cnt == 4'hF) begin
            err     <= 1'b1;
            state   <= IDLE;
            retired <= retired + 32'd1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
